serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, width 1: request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, width WIDTH: augend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, width WIDTH: addend, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, width 1: carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, width 1: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, width 1: one-cycle pulse, result valid.
REQ-010 The block SHALL have port sum, output, width WIDTH: registered result a+b+cin mod 2^WIDTH.
REQ-011 The block SHALL have port cout, output, width 1: registered carry-out of the MSB.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL on that edge load a and b into internal shift registers, load cin into the carry flop, clear the bit counter, and go to RUN.
REQ-014 In each RUN cycle, the block SHALL compute bit = A[0]^B[0]^carry and carry = majority(A[0],B[0],carry), shift bit into the MSB of the internal result register, shift A and B right by one, and increment the counter.
REQ-015 After exactly WIDTH RUN edges, the block SHALL copy the internal result to sum and the carry to cout, and go to DONE; done is first visible WIDTH edges after the start-sampling edge.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-017 start SHALL be ignored in RUN and DONE, so no queuing occurs; a start asserted in DONE has no effect and must be re-asserted in IDLE.
REQ-018 A start held high continuously SHALL launch a new operation on each IDLE cycle, giving a period of WIDTH+2 cycles.
REQ-019 sum and cout SHALL change only on the edge entering DONE and hold otherwise, including through the following operation until its completion; partial results are never visible.
REQ-020 Changes on a, b or cin after the accept edge SHALL NOT affect the result.

Reset
REQ-021 When rst=1 at a rising edge, the block SHALL go to IDLE and clear busy, done, sum, cout, the counter, the carry and the shift registers.
REQ-022 rst SHALL take priority over start and over all FSM activity; reset in mid-RUN aborts the operation, produces no done, and leaves sum=0.

Configuration
REQ-023 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output ovf (width 1) equal to (carry into MSB) XOR (carry out of MSB), signed two's-complement overflow, registered alongside sum and reset to 0.
REQ-024 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-025 The bench SHALL apply rst for 2 cycles, then check busy=0, done=0, sum=0x00, cout=0.
REQ-026 The bench SHALL apply a=0x3C, b=0x25, cin=0, pulse start, then check busy=1 for 9 cycles and done one cycle 8 edges later with sum=0x61, cout=0 (ovf=0).
REQ-027 The bench SHALL apply a=0xFF, b=0x00, cin=1, then check sum=0x00, cout=1 (ovf=0); and apply a=0x7F, b=0x01, cin=0, then check sum=0x80, cout=0, ovf=1.
REQ-028 The bench SHALL pulse start with a=0x10, b=0x20, change a/b to 0xAA/0x55 and pulse start again during RUN, then check a single done with sum=0x30 and no second done.
REQ-029 The bench SHALL start a=0xF0, b=0x0F, assert rst at the 4th RUN cycle, then check no done, busy=0 next cycle, sum=0x00, and that a subsequent normal operation completes correctly.
REQ-030 The bench SHALL hold start=1 continuously with fixed operands, then check that done pulses every 10 cycles with a correct sum.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one sum bit per clock, LSB first, result published on entry to DONE.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             bit_s, carry_n, last_bit;

  // One full-adder slice working on the LSBs of the operand shift registers.
  assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry_q;
  assign carry_n  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
  assign res_next = {bit_s, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // NOTE: combinational blocks assign every output a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            res_sr  <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next;
          carry_q <= carry_n;
          cnt_q   <= cnt_q + CW'(1);
          // The final slice is folded straight into the outputs so done lands WIDTH edges after accept.
          if (last_bit) begin
            sum  <= res_next;
            cout <= carry_n;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB slice differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      ovf <= carry_q ^ carry_n;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks compile in with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst, start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] held_sum = 8'h00;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one addition and check every cycle through DONE and the return to IDLE.
  // With disturb set, operands change and start pulses mid-RUN and again during DONE.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic [7:0] es, input logic ec,
                        input logic eo, input bit disturb);
    a = ia; b = ib; cin = icin; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_busy_run%0d", tag, i), busy, 1'b1);
      check($sformatf("%s_done_run%0d", tag, i), done, 1'b0);
      check($sformatf("%s_sum_hold%0d", tag, i), sum, held_sum);
      if (disturb && i == 2) begin
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check({tag, "_busy_done"}, busy, 1'b1);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", tag);
`endif
    if (disturb) start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_done_idle"}, done, 1'b0);
    check({tag, "_sum_after"}, sum, es);
    check({tag, "_cout_after"}, cout, ec);
    held_sum = es;
  endtask

  initial begin
    int last_done;
    int n_done;

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif

    // 0x3C + 0x25 = 0x61
    run_op("op3c25", 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0);
    // 0xFF + 0x00 + 1 = 0x100: sum wraps, carry out set, no signed overflow
    run_op("opff00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    // 0x7F + 0x01 = 0x80: signed overflow
    run_op("op7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    // Operands change and start re-pulses during RUN/DONE; result must stay 0x30
    run_op("opq1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) n_done++;
      if (busy) n_done++;
      step();
    end
    check("noq_no_second_op", n_done, 0);
    check("noq_sum_hold", sum, 8'h30);

    // Abort in the 4th RUN cycle: reset sampled on the 4th edge after accept
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) n_done++;
      step();
    end
    check("abort_no_done", n_done, 0);
    held_sum = 8'h00;
    // 0x5A + 0x33 + 1 = 0x8E: signed overflow, no carry out
    run_op("op5a33", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1, 1'b0);

    // Continuous start: done every WIDTH+2 = 10 cycles, first at the 8th cycle
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    last_done = -1;
    n_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      if (done) begin
        check($sformatf("cont_sum%0d", n_done), sum, 8'h46);
        check($sformatf("cont_cout%0d", n_done), cout, 1'b0);
        if (last_done < 0) check("cont_first_latency", cyc, 8);
        else check($sformatf("cont_period%0d", n_done), cyc - last_done, 10);
        last_done = cyc;
        n_done++;
      end
    end
    start = 1'b0;
    check("cont_done_count", n_done, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
